// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I core: one instruction per clock from a combinational
// program memory, combinational data reads and clocked byte-enabled stores.
// EBREAK latches a halt flag that freezes the PC and blocks all writes.
module rv32i_single_cycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] memory_address,
  input  logic [31:0] memory_out,
  output logic [31:0] memory_write,
  output logic [3:0]  memory_byte_enable,
  output logic        memory_we,
  output logic        ebreak
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  logic [31:0] pc_reg, pc_next;
  logic        halt_reg;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'h000};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  // Execution is suppressed while reset is held or after the halt flag is set.
  logic is_ebreak, active;
  assign is_ebreak = (instruction == EBREAK_WORD);
  assign active    = !rst && !halt_reg && !is_ebreak;

  // Register file: x0 is never written, so it always reads as zero.
  logic [31:0] regs [0:31];
  logic [31:0] rs1_data, rs2_data, rd_data;
  logic        rd_write, rf_we;

  assign rs1_data = regs[rs1];
  assign rs2_data = regs[rs2];
  assign rf_we    = rd_write && active && (rd != 5'd0);

  // Register file write port; reset clears every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rf_we) begin
      regs[rd] <= rd_data;
    end
  end

  // ALU: second operand is rs2 for OP and the I-immediate for OP-IMM.
  // Bit 30 selects SUB/SRA; for OP-IMM it only means SRAI (ADDI has no SUB).
  logic [31:0] alu_b, alu_result, sra_result;
  logic        alu_alt;

  assign alu_b   = (opcode == OPC_OP) ? rs2_data : imm_i;
  assign alu_alt = instruction[30] &&
                   (((opcode == OPC_OP) && (funct3 == 3'b000 || funct3 == 3'b101)) ||
                    ((opcode == OPC_OP_IMM) && (funct3 == 3'b101)));
  assign sra_result = $signed(rs1_data) >>> alu_b[4:0];

  // ALU operation select.
  always_comb begin
    alu_result = '0;
    case (funct3)
      3'b000: alu_result = alu_alt ? (rs1_data - alu_b) : (rs1_data + alu_b);
      3'b001: alu_result = rs1_data << alu_b[4:0];
      3'b010: alu_result = {31'd0, $signed(rs1_data) < $signed(alu_b)};
      3'b011: alu_result = {31'd0, rs1_data < alu_b};
      3'b100: alu_result = rs1_data ^ alu_b;
      3'b101: alu_result = alu_alt ? sra_result : (rs1_data >> alu_b[4:0]);
      3'b110: alu_result = rs1_data | alu_b;
      default: alu_result = rs1_data & alu_b;
    endcase
  end

  // Branch condition evaluation; reserved funct3 codes never branch.
  logic branch_taken;
  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000: branch_taken = (rs1_data == rs2_data);
      3'b001: branch_taken = (rs1_data != rs2_data);
      3'b100: branch_taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101: branch_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110: branch_taken = (rs1_data <  rs2_data);
      3'b111: branch_taken = (rs1_data >= rs2_data);
      default: branch_taken = 1'b0;
    endcase
  end

  // Effective address; shared by loads, stores and JALR.
  logic [31:0] addr_sum;
  assign addr_sum       = rs1_data + ((opcode == OPC_STORE) ? imm_s : imm_i);
  assign memory_address = addr_sum;

  // Load lane extraction from the addressed word.
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic        load_valid;
  always_comb begin
    case (addr_sum[1:0])
      2'd0:    load_byte = memory_out[7:0];
      2'd1:    load_byte = memory_out[15:8];
      2'd2:    load_byte = memory_out[23:16];
      default: load_byte = memory_out[31:24];
    endcase
    load_half  = addr_sum[1] ? memory_out[31:16] : memory_out[15:0];
    load_data  = '0;
    load_valid = 1'b1;
    case (funct3)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b010:  load_data = memory_out;
      3'b100:  load_data = {24'd0, load_byte};
      3'b101:  load_data = {16'd0, load_half};
      default: load_valid = 1'b0;
    endcase
  end

  // Store lane placement: data replicated across lanes, mask picks the target.
  logic [3:0] store_be;
  always_comb begin
    store_be     = 4'b0000;
    memory_write = rs2_data;
    case (funct3)
      3'b000: begin
        store_be     = 4'b0001 << addr_sum[1:0];
        memory_write = {4{rs2_data[7:0]}};
      end
      3'b001: begin
        store_be     = addr_sum[1] ? 4'b1100 : 4'b0011;
        memory_write = {2{rs2_data[15:0]}};
      end
      3'b010: store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  end

  assign memory_we          = active && (opcode == OPC_STORE) && (store_be != 4'b0000);
  assign memory_byte_enable = memory_we ? store_be : 4'b0000;

  // Next-PC selection and writeback data; EBREAK and halt hold the PC.
  always_comb begin
    pc_next  = pc_reg + 32'd4;
    rd_data  = '0;
    rd_write = 1'b0;
    case (opcode)
      OPC_LUI: begin
        rd_data  = imm_u;
        rd_write = 1'b1;
      end
      OPC_AUIPC: begin
        rd_data  = pc_reg + imm_u;
        rd_write = 1'b1;
      end
      OPC_JAL: begin
        rd_data  = pc_reg + 32'd4;
        rd_write = 1'b1;
        pc_next  = pc_reg + imm_j;
      end
      OPC_JALR: begin
        rd_data  = pc_reg + 32'd4;
        rd_write = 1'b1;
        pc_next  = addr_sum & ~32'd1;
      end
      OPC_BRANCH: begin
        if (branch_taken) pc_next = pc_reg + imm_b;
      end
      OPC_LOAD: begin
        rd_data  = load_data;
        rd_write = load_valid;
      end
      OPC_OP_IMM, OPC_OP: begin
        rd_data  = alu_result;
        rd_write = 1'b1;
      end
      default: begin
        rd_write = 1'b0;
      end
    endcase
    if (is_ebreak || halt_reg) pc_next = pc_reg;
  end

  // PC register and halt flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg   <= RESET_PC;
      halt_reg <= 1'b0;
    end else begin
      pc_reg <= pc_next;
      if (is_ebreak) halt_reg <= 1'b1;
    end
  end

  assign pc     = pc_reg;
  assign ebreak = !rst && (halt_reg || is_ebreak);

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Self-checking bench for rv32i_single_cycle_core: directed programs plus
// random programs, checked each cycle against an instruction-level model
// that keeps data memory as a plain byte array.
module tb_rv32i_single_cycle_core;

  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  logic        clk, rst;
  logic [31:0] instruction, pc, memory_address, memory_out, memory_write;
  logic [3:0]  memory_byte_enable;
  logic        memory_we, ebreak;

  logic [31:0] rom  [0:255];
  logic [31:0] dram [0:255];

  // Reference model state.
  logic [7:0]  mb    [0:1023];
  logic [31:0] mregs [0:31];
  logic [31:0] mpc;
  bit          mhalt;

  int checks = 0;
  int fails  = 0;
  int pidx;
  int we_count;
  bit first_seen;
  logic [3:0]  first_be;
  logic [31:0] first_wd;

  assign instruction = rom[pc[9:2]];
  assign memory_out  = dram[memory_address[9:2]];

  rv32i_single_cycle_core dut (
    .clk                (clk),
    .rst                (rst),
    .instruction        (instruction),
    .pc                 (pc),
    .memory_address     (memory_address),
    .memory_out         (memory_out),
    .memory_write       (memory_write),
    .memory_byte_enable (memory_byte_enable),
    .memory_we          (memory_we),
    .ebreak             (ebreak)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction encoders.
  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] b_type(input int off, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    logic [12:0] v;
    v = 13'(off);
    return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], 7'h63};
  endfunction
  function automatic logic [31:0] u_type(input logic [19:0] imm, input logic [4:0] rd,
      input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] j_type(input int off, input logic [4:0] rd);
    logic [20:0] v;
    v = 21'(off);
    return {v[20], v[10:1], v[11], v[19:12], rd, 7'h6F};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 32'h0000_0013;
    pidx = 0;
  endtask

  task automatic emit(input logic [31:0] ins);
    rom[pidx] = ins;
    pidx++;
  endtask

  task automatic fill_ram(input bit randomize, input logic [31:0] value);
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = randomize ? $urandom : value;
      dram[i] = w;
      for (int k = 0; k < 4; k++) mb[4*i+k] = w[8*k +: 8];
    end
  endtask

  function automatic logic [31:0] model_word(input int i);
    return {mb[4*i+3], mb[4*i+2], mb[4*i+1], mb[4*i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mpc   = 32'h0;
    mhalt = 1'b0;
  endtask

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic [31:0] x,
      input logic [31:0] y, input bit alt);
    logic [31:0] r;
    case (f3)
      3'd0: r = alt ? x - y : x + y;
      3'd1: r = x << y[4:0];
      3'd2: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: r = (x < y) ? 32'd1 : 32'd0;
      3'd4: r = x ^ y;
      3'd5: begin
        if (alt) r = $signed(x) >>> y[4:0];
        else     r = x >> y[4:0];
      end
      3'd6: r = x | y;
      default: r = x & y;
    endcase
    return r;
  endfunction

  // Executes the instruction at mpc; reports what the core should show this cycle.
  task automatic model_step(output bit e_we, output logic [3:0] e_be, output logic [31:0] e_wd,
      output logic [31:0] e_addr, output bit e_mem, output bit e_eb);
    logic [31:0] ins, a, b, ii, is, ib, iu, ij, ea, res, npc;
    logic [15:0] h;
    logic [2:0]  f3;
    logic [4:0]  rd;
    bit wr, taken;
    int ba;
    e_we = 0; e_be = '0; e_wd = '0; e_addr = '0; e_mem = 0; e_eb = mhalt;
    if (mhalt) return;
    ins = rom[mpc[9:2]];
    if (ins == EBREAK_WORD) begin
      e_eb  = 1;
      mhalt = 1;
      return;
    end
    f3 = ins[14:12];
    rd = ins[11:7];
    a  = mregs[ins[19:15]];
    b  = mregs[ins[24:20]];
    ii = 32'($signed(ins[31:20]));
    is = 32'($signed({ins[31:25], ins[11:7]}));
    ib = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    iu = {ins[31:12], 12'h000};
    ij = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    npc = mpc + 4;
    wr  = 0;
    res = '0;
    case (ins[6:0])
      7'h37: begin res = iu; wr = 1; end
      7'h17: begin res = mpc + iu; wr = 1; end
      7'h6F: begin res = mpc + 4; wr = 1; npc = mpc + ij; end
      7'h67: begin res = mpc + 4; wr = 1; npc = (a + ii) & ~32'd1; end
      7'h63: begin
        case (f3)
          3'd0: taken = (a == b);
          3'd1: taken = (a != b);
          3'd4: taken = $signed(a) <  $signed(b);
          3'd5: taken = $signed(a) >= $signed(b);
          3'd6: taken = a < b;
          3'd7: taken = a >= b;
          default: taken = 0;
        endcase
        if (taken) npc = mpc + ib;
      end
      7'h03: begin
        ea = a + ii; e_addr = ea; e_mem = 1;
        ba = int'(ea[9:0]);
        h  = {mb[(ba & ~1) + 1], mb[ba & ~1]};
        case (f3)
          3'd0: begin res = 32'($signed(mb[ba])); wr = 1; end
          3'd4: begin res = {24'd0, mb[ba]}; wr = 1; end
          3'd1: begin res = 32'($signed(h)); wr = 1; end
          3'd5: begin res = {16'd0, h}; wr = 1; end
          3'd2: begin res = model_word(ba / 4); wr = 1; end
          default: wr = 0;
        endcase
      end
      7'h23: begin
        ea = a + is; e_addr = ea; e_mem = 1;
        ba = int'(ea[9:0]);
        case (f3)
          3'd0: begin
            mb[ba] = b[7:0];
            e_we = 1; e_be = 4'b0001 << ea[1:0]; e_wd = {4{b[7:0]}};
          end
          3'd1: begin
            mb[ba & ~1] = b[7:0]; mb[(ba & ~1) + 1] = b[15:8];
            e_we = 1; e_be = ea[1] ? 4'b1100 : 4'b0011; e_wd = {2{b[15:0]}};
          end
          3'd2: begin
            for (int k = 0; k < 4; k++) mb[(ba & ~3) + k] = b[8*k +: 8];
            e_we = 1; e_be = 4'b1111; e_wd = b;
          end
          default: e_we = 0;
        endcase
      end
      7'h13: begin res = alu(f3, a, ii, (f3 == 3'd5) && ins[30]); wr = 1; end
      7'h33: begin res = alu(f3, a, b, ins[30]); wr = 1; end
      default: wr = 0;
    endcase
    if (wr && rd != 0) mregs[rd] = res;
    mpc = npc;
  endtask

  // Advance one clock: the bench RAM commits whatever store the core presents.
  task automatic tick();
    logic s_we;
    logic [3:0] s_be;
    logic [31:0] s_wd, s_a;
    s_we = memory_we; s_be = memory_byte_enable; s_wd = memory_write; s_a = memory_address;
    @(posedge clk);
    if (s_we === 1'b1)
      for (int k = 0; k < 4; k++)
        if (s_be[k]) dram[s_a[9:2]][8*k +: 8] = s_wd[8*k +: 8];
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_pc", pc, 32'h0);
    check("reset_ebreak", 32'(ebreak), 32'd0);
    check("reset_we", 32'(memory_we), 32'd0);
    tick();
    tick();
    model_reset();
  endtask

  task automatic release_reset();
    rst = 1'b0;
    #1;
  endtask

  task automatic run(input int max_cycles, input bit expect_halt);
    bit e_we, e_mem, e_eb;
    logic [3:0] e_be;
    logic [31:0] e_wd, e_addr, cur;
    int halted_cycles;
    halted_cycles = 0;
    we_count = 0;
    first_seen = 0;
    for (int n = 0; n < max_cycles; n++) begin
      cur = mpc;
      model_step(e_we, e_be, e_wd, e_addr, e_mem, e_eb);
      check("pc", pc, cur);
      check("ebreak", 32'(ebreak), 32'(e_eb));
      check("memory_we", 32'(memory_we), 32'(e_we));
      check("byte_enable", 32'(memory_byte_enable), 32'(e_be));
      if (e_mem) check("memory_address", memory_address, e_addr);
      if (e_we) check("memory_write", memory_write, e_wd);
      if (memory_we === 1'b1) begin
        we_count++;
        if (!first_seen) begin
          first_seen = 1;
          first_be = memory_byte_enable;
          first_wd = memory_write;
        end
      end
      if (mhalt) halted_cycles++;
      if (expect_halt && halted_cycles >= 3) break;
      tick();
    end
    if (expect_halt) check("halt_reached", 32'(ebreak), 32'd1);
  endtask

  task automatic compare_ram(input string tag);
    for (int i = 0; i < 256; i++)
      check($sformatf("%s ram[%0d]", tag, i), dram[i], model_word(i));
  endtask

  task automatic emit_random_alu();
    logic [4:0] rd, ra, rb;
    logic [2:0] f3;
    rd = 5'($urandom_range(0, 7));
    ra = 5'($urandom_range(0, 7));
    rb = 5'($urandom_range(0, 7));
    f3 = 3'($urandom_range(0, 7));
    emit(r_type(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                rb, ra, f3, rd));
  endtask

  task automatic emit_random_op();
    logic [4:0]  rd, ra, rb;
    logic [2:0]  f3;
    logic [11:0] imm;
    int kind;
    kind = $urandom_range(0, 5);
    rd = 5'($urandom_range(0, 7));
    ra = 5'($urandom_range(0, 7));
    rb = 5'($urandom_range(0, 7));
    f3 = 3'($urandom_range(0, 7));
    case (kind)
      0: emit_random_alu();
      1: begin
        if (f3 == 3'd1)      imm = {7'h00, 5'($urandom)};
        else if (f3 == 3'd5) imm = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, 5'($urandom)};
        else                 imm = 12'($urandom);
        emit(i_type(imm, ra, f3, rd, 7'h13));
      end
      2: begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
        emit(i_type(12'(32'h200 + $urandom_range(0, 511)), 5'd0, f3, rd, 7'h03));
      end
      3: emit(s_type(12'(32'h200 + $urandom_range(0, 511)), rb, 5'd0, 3'($urandom_range(0, 2))));
      4: begin
        case ($urandom_range(0, 5))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd4;
          3: f3 = 3'd5;
          4: f3 = 3'd6;
          default: f3 = 3'd7;
        endcase
        emit(b_type(8, rb, ra, f3));
        emit_random_alu();
      end
      default: emit(u_type(20'($urandom), rd, ($urandom_range(0, 1) == 1) ? 7'h17 : 7'h37));
    endcase
  endtask

  initial begin
    rst = 1'b1;

    // addi/addi/add/sw/ebreak.
    apply_reset();
    clear_rom();
    emit(i_type(12'd5, 5'd0, 3'd0, 5'd1, 7'h13));
    emit(i_type(12'd7, 5'd0, 3'd0, 5'd2, 7'h13));
    emit(r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
    emit(s_type(12'd0, 5'd3, 5'd0, 3'd2));
    emit(EBREAK_WORD);
    fill_ram(0, 32'hDEAD_BEEF);
    release_reset();
    run(40, 1);
    check("p1_ram0", dram[0], 32'd12);
    check("p1_we_pulses", 32'(we_count), 32'd1);
    check("p1_be", 32'(first_be), 32'hF);
    check("p1_pc_frozen", pc, 32'd16);
    compare_ram("p1");

    // Byte store replication and signed/unsigned byte loads.
    apply_reset();
    check("halted_reset_ebreak", 32'(ebreak), 32'd0);
    clear_rom();
    emit(i_type(12'h0AB, 5'd0, 3'd0, 5'd5, 7'h13));
    emit(s_type(12'd3, 5'd5, 5'd0, 3'd0));
    emit(i_type(12'd3, 5'd0, 3'd0, 5'd6, 7'h03));
    emit(i_type(12'd3, 5'd0, 3'd4, 5'd7, 7'h03));
    emit(s_type(12'd16, 5'd6, 5'd0, 3'd2));
    emit(s_type(12'd20, 5'd7, 5'd0, 3'd2));
    emit(EBREAK_WORD);
    fill_ram(0, 32'hDEAD_BEEF);
    release_reset();
    run(40, 1);
    check("p2_sb_be", 32'(first_be), 32'h8);
    check("p2_sb_data", first_wd, 32'hABAB_ABAB);
    check("p2_ram0", dram[0], 32'hABAD_BEEF);
    check("p2_lb", dram[4], 32'hFFFF_FFAB);
    check("p2_lbu", dram[5], 32'h0000_00AB);
    compare_ram("p2");

    // Branches, JAL and JALR.
    apply_reset();
    clear_rom();
    emit(b_type(8, 5'd0, 5'd0, 3'd0));
    emit(i_type(12'd1, 5'd0, 3'd0, 5'd10, 7'h13));
    emit(b_type(8, 5'd0, 5'd0, 3'd1));
    emit(i_type(12'd2, 5'd0, 3'd0, 5'd11, 7'h13));
    emit(j_type(16, 5'd1));
    emit(s_type(12'd24, 5'd10, 5'd0, 3'd2));
    emit(s_type(12'd28, 5'd11, 5'd0, 3'd2));
    emit(EBREAK_WORD);
    emit(s_type(12'd32, 5'd1, 5'd0, 3'd2));
    emit(i_type(12'd0, 5'd1, 3'd0, 5'd0, 7'h67));
    fill_ram(0, 32'hDEAD_BEEF);
    release_reset();
    run(40, 1);
    check("p3_skipped", dram[6], 32'd0);
    check("p3_fallthrough", dram[7], 32'd2);
    check("p3_link", dram[8], 32'd20);
    check("p3_pc_frozen", pc, 32'd28);
    compare_ram("p3");

    // x0 hardwiring, SLT vs SLTU, SRAI.
    apply_reset();
    clear_rom();
    emit(i_type(12'd9, 5'd0, 3'd0, 5'd0, 7'h13));
    emit(r_type(7'h00, 5'd0, 5'd0, 3'd0, 5'd4));
    emit(s_type(12'd0, 5'd4, 5'd0, 3'd2));
    emit(i_type(12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13));
    emit(i_type(12'd1, 5'd0, 3'd0, 5'd2, 7'h13));
    emit(r_type(7'h00, 5'd2, 5'd1, 3'd2, 5'd3));
    emit(r_type(7'h00, 5'd2, 5'd1, 3'd3, 5'd7));
    emit(u_type(20'h80000, 5'd5, 7'h37));
    emit(i_type(12'h404, 5'd5, 3'd5, 5'd6, 7'h13));
    emit(s_type(12'd4, 5'd3, 5'd0, 3'd2));
    emit(s_type(12'd8, 5'd7, 5'd0, 3'd2));
    emit(s_type(12'd12, 5'd6, 5'd0, 3'd2));
    emit(EBREAK_WORD);
    fill_ram(0, 32'hDEAD_BEEF);
    release_reset();
    run(40, 1);
    check("p4_x0", dram[0], 32'd0);
    check("p4_slt", dram[1], 32'd1);
    check("p4_sltu", dram[2], 32'd0);
    check("p4_srai", dram[3], 32'hF800_0000);
    compare_ram("p4");

    // Reset asserted in the middle of a store cycle.
    apply_reset();
    clear_rom();
    emit(i_type(12'd1, 5'd1, 3'd0, 5'd1, 7'h13));
    emit(s_type(12'd0, 5'd1, 5'd0, 3'd2));
    emit(j_type(-8, 5'd0));
    fill_ram(0, 32'h0);
    release_reset();
    run(4, 0);
    check("mid_pre_pc", pc, 32'd4);
    check("mid_pre_we", 32'(memory_we), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_pc", pc, 32'd0);
    check("mid_rst_ebreak", 32'(ebreak), 32'd0);
    check("mid_rst_we", 32'(memory_we), 32'd0);
    tick();
    tick();
    check("mid_rst_no_write", dram[0], 32'd1);
    model_reset();
    release_reset();
    run(7, 0);
    check("mid_restart_ram0", dram[0], 32'd2);
    compare_ram("mid");

    // Random programs.
    for (int p = 0; p < 5; p++) begin
      apply_reset();
      clear_rom();
      for (int r = 1; r < 8; r++) begin
        emit(u_type(20'($urandom), 5'(r), 7'h37));
        emit(i_type(12'($urandom), 5'(r), 3'd0, 5'(r), 7'h13));
      end
      for (int n = 0; n < 30; n++) emit_random_op();
      for (int r = 1; r < 8; r++) emit(s_type(12'(256 + 4*(r-1)), 5'(r), 5'd0, 3'd2));
      emit(EBREAK_WORD);
      fill_ram(1, 32'h0);
      release_reset();
      run(200, 1);
      compare_ram($sformatf("rand%0d", p));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rv32i_single_cycle_core.md
# rv32i_single_cycle_core

Single-cycle RV32I integer core that fetches one instruction per clock from a combinational program memory and accesses a byte-addressed data RAM with combinational reads and clocked byte-enabled writes. It is the processor block of the CPU subsystem, sitting between the program ROM (driven by `pc`) and the data RAM (driven by the memory_* ports). It signals completion to the surrounding system via `ebreak`.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instruction`  in  32  instruction at `pc`, valid combinationally in the same cycle.
- `pc`  out  32  current instruction byte address (registered).
- `memory_address`  out  32  data byte address (rs1 + imm) for loads/stores.
- `memory_out`  in  32  RAM read data: the word at `memory_address & ~3`, combinational.
- `memory_write`  out  32  store data, already shifted into byte lanes.
- `memory_byte_enable`  out  4  store lane mask; bit i covers data bits [8i+7:8i].
- `memory_we`  out  1  store strobe; RAM writes enabled lanes on the rising edge.
- `ebreak`  out  1  high when EBREAK is executing or the core has halted.
- Clock is one clock; reset is asynchronous and active-high.

## Operation
- Executes RV32I: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP ALU ops.
- Register file: 32×32, x0 reads 0, writes to x0 are discarded. Two combinational read ports, one write port written on the rising edge.
- Next PC:
  - pc+4 by default.
  - pc+imm for JAL and for taken branches.
  - (rs1+imm) & ~1 for JALR.
  - JAL/JALR write pc+4 to rd.
- All arithmetic is mod 2^32. Shifts use the low 5 bits of the shift amount. SLT/SLTI are signed; SLTU/SLTIU are unsigned.
- Loads select lanes from `memory_out` using `memory_address[1:0]`:
  - byte: lane = addr[1:0].
  - halfword: lane = addr[1] × 2.
  - word: addr[1:0] ignored.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Stores:
  - SB: data byte replicated to all 4 lanes, enable = 1 << addr[1:0].
  - SH: halfword replicated to both halves, enable = 4'b0011 or 4'b1100 by addr[1].
  - SW: enable = 4'b1111.
- Misaligned accesses are not trapped; they behave per the lane rules above.
- `memory_we` is high only during a store cycle; otherwise `memory_byte_enable` = 0.
- EBREAK (32'h0010_0073):
  - `ebreak` rises combinationally in that cycle.
  - On the next edge a halt flag sets; thereafter `pc` is frozen, with no register or memory writes.
  - `ebreak` stays high until reset.
- FENCE, ECALL, CSR ops and unknown opcodes execute as NOPs (pc+4, no writes).

## Timing
- Reset (asynchronous):
  - `pc` = RESET_PC; halt flag cleared; all registers cleared to 0.
  - While `rst` is high: `memory_we` = 0, `ebreak` = 0, no register writes.
- Deassertion: the first instruction at RESET_PC executes in the first full cycle after `rst` falls.
- Latency: one instruction per cycle. Register and memory results are visible to the next instruction, with no hazards.
- Load: address and data resolve combinationally within the cycle; rd is written at the edge.
- Store: RAM is updated at the edge that ends the cycle.
- Reset mid-program: state is discarded immediately; no partial write is committed if `rst` rises before the edge.

## Test plan
- addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; sw x3,0(x0); ebreak -> RAM word 0 = 12; `memory_we` pulses for one cycle with enable 4'b1111; `ebreak` high, then `pc` frozen at the ebreak address.
- sb with x5=0xAB to address 3 -> `memory_byte_enable`=4'b1000, `memory_write`=0xABABABAB; then lb from address 3 -> 0xFFFFFFAB, lbu -> 0x000000AB.
- beq x0,x0,+8 -> `pc` skips one instruction; bne x0,x0,+8 -> pc+4; jal x1,+16 -> x1 = old pc+4, pc+16; jalr x0,x1,0 returns.
- addi x0,x0,9 then add x4,x0,x0 -> x4 = 0.
- slt vs sltu with x1=0xFFFFFFFF, x2=1 -> slt = 1, sltu = 0; srai of 0x80000000 by 4 -> 0xF8000000.
- `rst` asserted mid-program -> `pc` = 0 immediately, `ebreak` = 0, no `memory_we`; execution restarts from address 0 after release.
